// File: rtl/fetch_unit.sv
// Instruction-fetch front end for the SLC-3 core: owns PC, MAR, MDR and IR.
// Optional single-step pause after each fetch when SINGLE_STEP_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | not fetching, registers held; waits for run_i
// FETCH1  | MAR <= PC, PC <= PC+1
// FETCH2  | memory enabled for MEM_WAIT cycles, MDR captured on last
// FETCH3  | IR <= MDR, ir_valid_o pulses next cycle
// PAUSE   | single-step hold, released by a rising edge on continue_i
module fetch_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0,
    parameter int MEM_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic              continue_i,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_mem_ena,
    output logic              mem_wr_ena,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] ir_o,
    output logic              ir_valid_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] hex_display_debug
);

    localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(RESET_PC);
    localparam logic [3:0]        WAIT_LAST = 4'(MEM_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH1,
        S_FETCH2,
        S_FETCH3,
        S_PAUSE
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] mar, mar_n;
    logic [DATA_W-1:0] mdr, mdr_n;
    logic [DATA_W-1:0] ir, ir_n;
    logic [3:0]        wait_cnt, wait_n;
    logic              ir_valid_q, valid_n;
    logic              cont_rise;

`ifdef SINGLE_STEP_EN
    logic cont_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cont_q <= 1'b0;
        end else begin
            cont_q <= continue_i;
        end
    end

    assign cont_rise = continue_i & ~cont_q;
`else
    wire unused_continue = continue_i;
    assign cont_rise = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc         <= PC_RST;
            mar        <= '0;
            mdr        <= '0;
            ir         <= '0;
            wait_cnt   <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            mar        <= mar_n;
            mdr        <= mdr_n;
            ir         <= ir_n;
            wait_cnt   <= wait_n;
            ir_valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        mar_n   = mar;
        mdr_n   = mdr;
        ir_n    = ir;
        wait_n  = wait_cnt;
        valid_n = 1'b0;

        // A redirect always wins the PC, including over the FETCH1 increment.
        if (redirect_valid_i) begin
            pc_n = redirect_pc_i;
        end

        case (state)
            S_IDLE: begin
                if (!redirect_valid_i && run_i) begin
                    state_n = S_FETCH1;
                end
            end
            S_FETCH1: begin
                mar_n  = pc;
                wait_n = '0;
                if (redirect_valid_i) begin
                    state_n = S_FETCH1;
                end else begin
                    pc_n    = pc + 1'b1;
                    state_n = S_FETCH2;
                end
            end
            S_FETCH2: begin
                if (redirect_valid_i) begin
                    wait_n  = '0;
                    state_n = S_FETCH1;
                end else if (wait_cnt == WAIT_LAST) begin
                    mdr_n   = mem_rdata;
                    wait_n  = '0;
                    state_n = S_FETCH3;
                end else begin
                    wait_n = wait_cnt + 4'd1;
                end
            end
            S_FETCH3: begin
                if (redirect_valid_i) begin
                    state_n = S_FETCH1;
                end else begin
                    ir_n    = mdr;
                    valid_n = 1'b1;
`ifdef SINGLE_STEP_EN
                    state_n = S_PAUSE;
`else
                    state_n = run_i ? S_FETCH1 : S_IDLE;
`endif
                end
            end
            S_PAUSE: begin
                if (!redirect_valid_i) begin
                    if (!run_i) begin
                        state_n = S_IDLE;
                    end else if (cont_rise) begin
                        state_n = S_FETCH1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign mem_wdata         = mdr;
    assign mem_addr          = mar;
    assign mem_mem_ena       = (state == S_FETCH2);
    assign mem_wr_ena        = 1'b0;
    assign pc_o              = pc;
    assign ir_o              = ir;
    assign ir_valid_o        = ir_valid_q;
    assign busy_o            = (state != S_IDLE);
    assign hex_display_debug = ir;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two configurations (MEM_WAIT=1 16-bit, MEM_WAIT=3 4-bit wrap)
// checked every cycle against a fetch-position model, plus directed literal checks.
module tb_fetch_unit;

`ifdef SINGLE_STEP_EN
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        cont = 1'b0;
    logic        rv = 1'b0;
    logic [15:0] rpc = '0;

    logic [15:0] rdata_a, wdata_a, addr_a, pc_a, ir_a, hex_a;
    logic        ena_a, wr_a, va, busy_a;
    logic [15:0] rdata_b, wdata_b, ir_b, hex_b;
    logic [3:0]  addr_b, pc_b;
    logic        ena_b, wr_b, vb, busy_b;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdata_a = mem[addr_a];
    assign rdata_b = mem[{12'b0, addr_b}];

    fetch_unit #(.DATA_W(16), .ADDR_W(16), .RESET_PC(0), .MEM_WAIT(1)) dut_a (
        .clk(clk), .reset(reset), .run_i(run), .continue_i(cont),
        .redirect_valid_i(rv), .redirect_pc_i(rpc), .mem_rdata(rdata_a),
        .mem_wdata(wdata_a), .mem_addr(addr_a), .mem_mem_ena(ena_a), .mem_wr_ena(wr_a),
        .pc_o(pc_a), .ir_o(ir_a), .ir_valid_o(va), .busy_o(busy_a), .hex_display_debug(hex_a)
    );

    fetch_unit #(.DATA_W(16), .ADDR_W(4), .RESET_PC(15), .MEM_WAIT(3)) dut_b (
        .clk(clk), .reset(reset), .run_i(run), .continue_i(cont),
        .redirect_valid_i(rv), .redirect_pc_i(rpc[3:0]), .mem_rdata(rdata_b),
        .mem_wdata(wdata_b), .mem_addr(addr_b), .mem_mem_ena(ena_b), .mem_wr_ena(wr_b),
        .pc_o(pc_b), .ir_o(ir_b), .ir_valid_o(vb), .busy_o(busy_b), .hex_display_debug(hex_b)
    );

    // pos: 0 = not fetching, 1 = address cycle, 2..mw+1 = wait cycles, mw+2 = IR load cycle
    typedef struct {
        int pos;
        bit paused;
        int pc;
        int mar;
        int mdr;
        int ir;
        bit vld;
        bit cprev;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset(int rst_pc, int aw);
        mdl_t n;
        n.pos = 0; n.paused = 0; n.pc = rst_pc & ((1 << aw) - 1);
        n.mar = 0; n.mdr = 0; n.ir = 0; n.vld = 0; n.cprev = 0;
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t s, bit r, bit c, bit redir, int tgt, int mw, int aw);
        mdl_t n = s;
        int mask = (1 << aw) - 1;
        n.vld   = 0;
        n.cprev = c;
        if (redir) n.pc = tgt & mask;
        if (s.paused) begin
            if (!redir) begin
                if (!r) n.paused = 0;
                else if (c && !s.cprev) begin n.paused = 0; n.pos = 1; end
            end
        end else if (s.pos == 0) begin
            if (r && !redir) n.pos = 1;
        end else if (s.pos == 1) begin
            n.mar = s.pc;
            if (!redir) begin n.pc = (s.pc + 1) & mask; n.pos = 2; end
        end else if (redir) begin
            n.pos = 1;
        end else if (s.pos <= mw + 1) begin
            if (s.pos == mw + 1) n.mdr = int'(mem[s.mar]);
            n.pos = s.pos + 1;
        end else begin
            n.ir  = s.mdr;
            n.vld = 1;
            if (SS) begin n.pos = 0; n.paused = 1; end
            else n.pos = r ? 1 : 0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma <= mreset(0, 16);
            mb <= mreset(15, 4);
        end else begin
            ma <= mstep(ma, run, cont, rv, int'(rpc), 1, 16);
            mb <= mstep(mb, run, cont, rv, int'(rpc), 3, 4);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("a_pc", pc_a, ma.pc);
        chk("a_ir", ir_a, ma.ir);
        chk("a_hex", hex_a, ma.ir);
        chk("a_valid", va, ma.vld);
        chk("a_busy", busy_a, (ma.pos != 0 || ma.paused));
        chk("a_ena", ena_a, (ma.pos >= 2 && ma.pos <= 2));
        chk("a_addr", addr_a, ma.mar);
        chk("a_wdata", wdata_a, ma.mdr);
        chk("a_wr", wr_a, 0);
        chk("b_pc", pc_b, mb.pc);
        chk("b_ir", ir_b, mb.ir);
        chk("b_hex", hex_b, mb.ir);
        chk("b_valid", vb, mb.vld);
        chk("b_busy", busy_b, (mb.pos != 0 || mb.paused));
        chk("b_ena", ena_b, (mb.pos >= 2 && mb.pos <= 4));
        chk("b_addr", addr_b, mb.mar);
        chk("b_wdata", wdata_b, mb.mdr);
        chk("b_wr", wr_b, 0);
    end

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b0; run = 1'b0; rv = 1'b0; cont = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
    endtask

    int pa[$], ia[$], pb[$], adra[$], lens[$];
    int t0, runb, cnt, pc_b_first, addr_b_first;
    bit found, prev_ena_a, prev_ena_b;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0]     = 16'h1234;
        mem[1]     = 16'hABCD;
        mem[16'h40] = 16'h0F0F;

        // reset state
        @(posedge clk); #2;
        @(negedge clk);
        chk("rst_pc_a", pc_a, 0);
        chk("rst_pc_b", pc_b, 15);
        chk("rst_ir_a", ir_a, 0);
        chk("rst_busy_a", busy_a, 0);
        reset = 1'b1;

        // stream on both configurations
        @(posedge clk); #2;
        run = 1'b1;
        t0 = cyc;
        runb = 0; prev_ena_a = 0; prev_ena_b = 0; pc_b_first = -1; addr_b_first = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (va) begin pa.push_back(cyc); ia.push_back(int'(ir_a)); end
            if (vb) pb.push_back(cyc);
            if (ena_a && !prev_ena_a) adra.push_back(int'(addr_a));
            if (ena_b && !prev_ena_b && pc_b_first < 0) begin
                pc_b_first = int'(pc_b); addr_b_first = int'(addr_b);
            end
            if (ena_b) runb++;
            else if (runb != 0) begin lens.push_back(runb); runb = 0; end
            prev_ena_a = ena_a; prev_ena_b = ena_b;
        end
        chk("a_pulse_count", int'(pa.size() >= 2), 1);
        if (pa.size() >= 2) begin
            chk("a_first_latency", pa[0] - t0, 4);
            chk("a_pulse_gap", pa[1] - pa[0], 3);
            chk("a_ir0", ia[0], 16'h1234);
            chk("a_ir1", ia[1], 16'hABCD);
        end
        chk("a_addr_count", int'(adra.size() >= 2), 1);
        if (adra.size() >= 2) begin
            chk("a_addr0", adra[0], 0);
            chk("a_addr1", adra[1], 1);
        end
        chk("b_pulse_count", int'(pb.size() >= 2), 1);
        if (pb.size() >= 2) begin
            chk("b_first_latency", pb[0] - t0, 6);
            chk("b_pulse_gap", pb[1] - pb[0], 5);
        end
        chk("b_ena_runs", int'(lens.size() >= 1), 1);
        if (lens.size() >= 1) chk("b_ena_len", lens[0], 3);
        chk("b_wrap_addr", addr_b_first, 15);
        chk("b_wrap_pc", pc_b_first, 0);

        // asynchronous reset in the middle of FETCH2
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ena_a) found = 1;
        end
        chk("wait_fetch2", found, 1);
        #1 reset = 1'b0;
        #1;
        chk("amid_pc", pc_a, 0);
        chk("amid_ir", ir_a, 0);
        chk("amid_busy", busy_a, 0);
        chk("amid_ena", ena_a, 0);
        chk("amid_pc_b", pc_b, 15);
        run = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("post_reset_idle", busy_a, 0);

        // redirect during FETCH2
        do_reset();
        run = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ena_a) found = 1;
        end
        chk("wait_fetch2_redir", found, 1);
        rv = 1'b1; rpc = 16'h0040;
        @(posedge clk); #2;
        rv = 1'b0;
        found = 0; prev_ena_a = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ena_a && !prev_ena_a) begin
                chk("redir_addr", addr_a, 16'h0040);
                chk("redir_pc", pc_a, 16'h0041);
            end
            if (va) begin
                found = 1;
                chk("redir_ir", ir_a, 16'h0F0F);
            end
            prev_ena_a = ena_a;
        end
        chk("redir_pulse_seen", found, 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            run  = ($urandom_range(0, 9) != 0);
            rv   = ($urandom_range(0, 19) == 0);
            rpc  = 16'($urandom);
            cont = ($urandom_range(0, 3) == 0);
            if (i == 1500) begin
                reset = 1'b0;
                #3 reset = 1'b1;
            end
        end
        rv = 1'b0;

`ifdef SINGLE_STEP_EN
        do_reset();
        cont = 1'b1;
        run  = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (va) cnt++;
        end
        chk("ss_first_step", cnt, 1);
        @(posedge clk); #2 cont = 1'b0;
        @(posedge clk); #2 cont = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (va) cnt++;
        end
        chk("ss_second_step", cnt, 1);
`endif

        @(posedge clk); #2;
        run = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
